mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Round-robin arbiter sharing one single-ported M10K-style matrix memory port (256-bit word, 11-bit address, 1-cycle read latency) between several requesters, e.g. the element-wise FSM, the matrix multiplier and the host loader. It grants one request per cycle and registers the winning command onto the memory port. It returns read data to the issuing requester with a valid strobe. A lock input lets a requester hold the port for a burst (e.g. SINGLE_ACCESS consecutive beats), bounded by a forced-rotation limit.

## Interface
- NUM_REQ, 3: number of requesters (2..8); requester index 0 is lowest-numbered.
- ADDR_W, 11: memory word address width.
- DATA_W, 256: memory word width (BANDWIDTH*DATA_WIDTH).
- MAX_LOCK, 8: maximum consecutive grants to one locked requester while others wait.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- req_read  in  NUM_REQ  per-requester read request.
- req_write  in  NUM_REQ  per-requester write request; wins over req_read for the same requester.
- req_lock  in  NUM_REQ  hold port after this grant.
- req_address  in  NUM_REQ*ADDR_W  packed, requester i at [i*ADDR_W +: ADDR_W].
- req_writedata  in  NUM_REQ*DATA_W  packed likewise.
- grant  out  NUM_REQ  one-hot or zero; combinational; grant[i] means requester i's command is accepted this cycle.
- rd_valid  out  NUM_REQ  one-hot or zero; read data for requester i is on rd_data.
- rd_data  out  DATA_W  equals mem_readdata.
- mem_read  out  1  registered memory read strobe.
- mem_write  out  1  registered memory write strobe.
- mem_address  out  ADDR_W  registered.
- mem_writedata  out  DATA_W  registered.
- mem_readdata  in  DATA_W  valid the cycle after mem_read is sampled by the memory.

## Operation
- Active request: act[i] = req_read[i] | req_write[i]. If a requester has neither, it is not requesting. If both are set, the command is a write; no rd_valid is produced.
- State: rr_ptr (index of last winner, reset 0), owner (locked requester or none, reset none), lock_cnt (reset 0), and a two-stage read-tag pipeline (reset 0).
- Arbitration, combinational every cycle:
  - If owner is valid, act[owner] holds, and lock_cnt < MAX_LOCK, or no other act is set: grant owner.
  - Otherwise grant the first set act scanning from rr_ptr+1 upward, mod NUM_REQ. The owner is skipped in this scan when it is being forced off.
  - No act set: grant = 0.
- On a grant to i at a clock edge:
  - rr_ptr <= i.
  - mem_* <= requester i's command.
  - If req_lock[i], owner <= i. lock_cnt <= lock_cnt+1 when i was already owner, else 1.
  - If req_lock[i] is low, owner <= none and lock_cnt <= 0.
- With no grant: mem_read/mem_write <= 0, mem_address/mem_writedata hold, owner <= none, lock_cnt <= 0.
- Read return: a granted read of requester i loads tag stage 1. Stage 1 moves to stage 2 the next edge. rd_valid = stage 2 one-hot.
- Writes produce no response. Write-then-read to the same address by any requesters in consecutive grants returns the new data, because the memory port performs them in order.
- Reset: grant forced 0 while reset is high. All mem strobes, rd_valid, pointers, owner and lock_cnt are 0/none the cycle after reset. In-flight reads are discarded and never produce rd_valid.

## Timing
- Accept in cycle N. The mem_* command is visible in cycle N+1. mem_readdata and rd_valid[i] are in cycle N+2.
- Sustained throughput is 1 command/cycle. Back-to-back reads from different requesters give back-to-back rd_valid in grant order.
- Requesters must hold their command stable until grant. A requester may drop its request without being granted (no penalty).
- Worst-case wait for an unlocked requester is (NUM_REQ-1)*MAX_LOCK cycles.
- Simultaneous lock release and new request from the same requester: this is treated as a normal grant, and the owner is cleared if the lock is low.

## Test plan
- Single read: reset, then req_read[1]=1 at address 0x005 for one cycle. Expected: grant=3'b010 in N, mem_read=1 with mem_address=0x005 in N+1, rd_valid=3'b010 with rd_data=mem word in N+2.
- Round-robin: all three requesters assert reads continuously after reset. Expected grant order 1,2,0,1,2,0. rd_valid follows the same order, 2 cycles later.
- Lock limit: requester 0 locks and reads continuously while requester 2 reads, with MAX_LOCK=8. Expected: 8 consecutive grants to 0, then 1 grant to 2, then 0 regains the port.
- Lock with no contention: requester 0 locks alone for 20 cycles. Expected: 20 consecutive grants, no forced gaps.
- Write/read hazard: requester 0 writes 0xAA..AA to address 0x010, then requester 1 reads address 0x010 in the next cycle. Expected: mem_write then mem_read on consecutive cycles. rd_valid[1] is set with rd_data=0xAA..AA. req_read & req_write on the same requester: write only, no rd_valid.
- Reset mid-read: a read is granted in N and reset is asserted in N+1. Expected: rd_valid stays 0 through N+3, and all mem strobes are 0 after reset.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle between the requesters, the round-robin arbiter and the single memory port.
// Handshake: a requester holds req_read/req_write and its command stable until
// grant[i] is high in the same cycle; that cycle is the accept. No data is
// returned for writes; reads return rd_valid[i] two cycles after the accept.
interface mem_port_arbiter_if #(
   parameter int NUM_REQ = 3,
   parameter int ADDR_W  = 11,
   parameter int DATA_W  = 256
);
   logic [NUM_REQ-1:0]        req_read;
   logic [NUM_REQ-1:0]        req_write;
   logic [NUM_REQ-1:0]        req_lock;
   logic [NUM_REQ*ADDR_W-1:0] req_address;
   logic [NUM_REQ*DATA_W-1:0] req_writedata;
   logic [NUM_REQ-1:0]        grant;
   logic [NUM_REQ-1:0]        rd_valid;
   logic [DATA_W-1:0]         rd_data;
   logic                      mem_read;
   logic                      mem_write;
   logic [ADDR_W-1:0]         mem_address;
   logic [DATA_W-1:0]         mem_writedata;
   logic [DATA_W-1:0]         mem_readdata;
   logic                      lock_state;

   modport slave (
      input  req_read, req_write, req_lock, req_address, req_writedata, mem_readdata,
      output grant, rd_valid, rd_data, mem_read, mem_write, mem_address, mem_writedata,
             lock_state
   );

   modport master (
      output req_read, req_write, req_lock, req_address, req_writedata, mem_readdata,
      input  grant, rd_valid, rd_data, mem_read, mem_write, mem_address, mem_writedata,
             lock_state
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter with burst locking for one single-ported, 1-cycle-latency
// memory; registers the winning command and steers read data back by tag.
module mem_port_arbiter #(
   parameter int NUM_REQ  = 3,
   parameter int ADDR_W   = 11,
   parameter int DATA_W   = 256,
   parameter int MAX_LOCK = 8
) (
   input logic               clock,
   input logic               reset,
   mem_port_arbiter_if.slave bus
);
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(MAX_LOCK + 1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LOCK);

   typedef enum logic {ST_FREE = 1'b0, ST_LOCKED = 1'b1} lock_state_t;

   lock_state_t        state, state_next;
   logic [IDX_W-1:0]   owner, owner_next;
   logic [CNT_W-1:0]   lock_cnt, cnt_next;
   logic [IDX_W-1:0]   rr_ptr;

   logic [NUM_REQ-1:0] act;
   logic [NUM_REQ-1:0] owner_mask;
   logic               others;
   logic               owner_act;
   logic               keep_owner;
   logic               skip_owner;
   logic [IDX_W-1:0]   cand;
   logic               gnt_any;
   logic [IDX_W-1:0]   gnt_idx;
   logic [NUM_REQ-1:0] grant_oh;
   logic [NUM_REQ-1:0] read_oh;
   logic               sel_read;
   logic               sel_write;
   logic [ADDR_W-1:0]  sel_addr;
   logic [DATA_W-1:0]  sel_wdata;

   logic               mem_read_q;
   logic               mem_write_q;
   logic [ADDR_W-1:0]  mem_address_q;
   logic [DATA_W-1:0]  mem_writedata_q;
   logic [NUM_REQ-1:0] tag_s1, tag_s2;

   always_comb begin
      act        = bus.req_read | bus.req_write;
      owner_mask = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner;
      others     = |(act & ~owner_mask);
      owner_act  = (state == ST_LOCKED) && act[owner];
      keep_owner = owner_act && ((lock_cnt < MAX_CNT) || !others);
      // Owner still wants the port but has used its burst: rotate past it.
      skip_owner = owner_act && !keep_owner;

      gnt_any = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      if (keep_owner) begin
         gnt_any = 1'b1;
         gnt_idx = owner;
      end else begin
         for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!gnt_any && act[cand] && !(skip_owner && (cand == owner))) begin
               gnt_any = 1'b1;
               gnt_idx = cand;
            end
         end
      end
      if (reset) begin
         gnt_any = 1'b0;
      end

      grant_oh = '0;
      if (gnt_any) begin
         grant_oh[gnt_idx] = 1'b1;
      end
      read_oh = grant_oh & bus.req_read & ~bus.req_write;

      sel_read  = 1'b0;
      sel_write = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_oh[i]) begin
            sel_write = bus.req_write[i];
            sel_read  = bus.req_read[i] & ~bus.req_write[i];
            sel_addr  = bus.req_address[i*ADDR_W +: ADDR_W];
            sel_wdata = bus.req_writedata[i*DATA_W +: DATA_W];
         end
      end

      state_next = ST_FREE;
      owner_next = owner;
      cnt_next   = '0;
      if (gnt_any && bus.req_lock[gnt_idx]) begin
         state_next = ST_LOCKED;
         owner_next = gnt_idx;
         if ((state == ST_LOCKED) && (owner == gnt_idx)) begin
            cnt_next = (lock_cnt == MAX_CNT) ? MAX_CNT : lock_cnt + 1'b1;
         end else begin
            cnt_next = {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state           <= ST_FREE;
         owner           <= '0;
         lock_cnt        <= '0;
         rr_ptr          <= '0;
         mem_read_q      <= 1'b0;
         mem_write_q     <= 1'b0;
         mem_address_q   <= '0;
         mem_writedata_q <= '0;
         tag_s1          <= '0;
         tag_s2          <= '0;
      end else begin
         state    <= state_next;
         owner    <= owner_next;
         lock_cnt <= cnt_next;
         if (gnt_any) begin
            rr_ptr          <= gnt_idx;
            mem_read_q      <= sel_read;
            mem_write_q     <= sel_write;
            mem_address_q   <= sel_addr;
            mem_writedata_q <= sel_wdata;
         end else begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
         end
         tag_s1 <= read_oh;
         tag_s2 <= tag_s1;
      end
   end

   assign bus.grant         = grant_oh;
   assign bus.rd_valid      = tag_s2;
   assign bus.rd_data       = bus.mem_readdata;
   assign bus.mem_read      = mem_read_q;
   assign bus.mem_write     = mem_write_q;
   assign bus.mem_address   = mem_address_q;
   assign bus.mem_writedata = mem_writedata_q;
   assign bus.lock_state    = state;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: behavioural memory, grant checks per
// cycle and a read-return scoreboard fed when reads are expected to win.
module tb_mem_port_arbiter;
   localparam int NR = 3;
   localparam int AW = 11;
   localparam int DW = 256;
   localparam int W  = NR + DW;

   logic clock;
   logic reset;
   int   n_checks;
   int   n_fail;

   logic [W-1:0]  exp_q[$];
   logic [DW-1:0] wmem [logic [AW-1:0]];

   mem_port_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

   mem_port_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(8)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a);
      return {8{5'h15, 16'hC0DE, a}};
   endfunction

   // single-ported memory with one cycle read latency
   always @(posedge clock) begin
      if (bus.mem_write) wmem[bus.mem_address] = bus.mem_writedata;
      if (bus.mem_read) begin
         if (wmem.exists(bus.mem_address)) bus.mem_readdata <= wmem[bus.mem_address];
         else bus.mem_readdata <= pattern(bus.mem_address);
      end
   end

   task automatic check(input string tag, input logic [299:0] got, input logic [299:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // read-return scoreboard
   always @(negedge clock) begin
      if (bus.rd_valid !== '0) begin
         if (exp_q.size() == 0) begin
            check("rd_unexpected", 300'(bus.rd_valid), 300'(0));
         end else begin
            check("rd_return", 300'({bus.rd_valid, bus.rd_data}), 300'(exp_q.pop_front()));
         end
      end
   end

   // driver tasks
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_reqs();
      bus.req_read      = '0;
      bus.req_write     = '0;
      bus.req_lock      = '0;
      bus.req_address   = '0;
      bus.req_writedata = '0;
   endtask

   task automatic set_req(input int r, input logic rd, input logic wr, input logic lk,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
      bus.req_read[r]                = rd;
      bus.req_write[r]               = wr;
      bus.req_lock[r]                = lk;
      bus.req_address[r*AW +: AW]    = a;
      bus.req_writedata[r*DW +: DW]  = d;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle_reqs();
      repeat (2) step();
      reset = 1'b0;
   endtask

   function automatic logic [NR-1:0] oh(input int r);
      logic [NR-1:0] v;
      v = '0;
      v[r] = 1'b1;
      return v;
   endfunction

   task automatic expect_grant(input string tag, input int r, input logic [AW-1:0] a, input logic push);
      @(negedge clock);
      check(tag, 300'(bus.grant), 300'(oh(r)));
      if (push) exp_q.push_back({oh(r), pattern(a)});
   endtask

   initial begin
      int rr_seq[6];
      int lk_seq[10];
      logic [DW-1:0] aa;
      logic [DW-1:0] h55;
      n_checks = 0;
      n_fail   = 0;
      aa  = {32{8'hAA}};
      h55 = {32{8'h55}};
      reset = 1'b1;
      idle_reqs();

      // grant is suppressed while reset is high
      bus.req_read = '1;
      @(negedge clock);
      check("gnt_in_reset", 300'(bus.grant), 300'(0));
      step();
      idle_reqs();
      step();
      reset = 1'b0;
      @(negedge clock);
      check("rst_mem_read", 300'(bus.mem_read), 300'(0));
      check("rst_mem_write", 300'(bus.mem_write), 300'(0));
      check("rst_rd_valid", 300'(bus.rd_valid), 300'(0));
      check("rst_lock_state", 300'(bus.lock_state), 300'(0));

      // single read from requester 1
      step();
      set_req(1, 1'b1, 1'b0, 1'b0, 11'h005, '0);
      expect_grant("single_gnt", 1, 11'h005, 1'b1);
      step();
      idle_reqs();
      @(negedge clock);
      check("single_mem_read", 300'(bus.mem_read), 300'(1));
      check("single_mem_addr", 300'(bus.mem_address), 300'(11'h005));
      repeat (3) step();

      // round-robin among three continuous readers
      do_reset();
      rr_seq = '{1, 2, 0, 1, 2, 0};
      for (int r = 0; r < NR; r++) set_req(r, 1'b1, 1'b0, 1'b0, AW'(11'h020 + r), '0);
      foreach (rr_seq[k]) begin
         expect_grant("rr_gnt", rr_seq[k], AW'(11'h020 + rr_seq[k]), 1'b1);
         step();
      end
      idle_reqs();
      repeat (3) step();

      // lock limit: requester 0 locked, requester 2 contending
      do_reset();
      set_req(0, 1'b1, 1'b0, 1'b1, 11'h030, '0);
      expect_grant("lk_first", 0, 11'h030, 1'b1);
      step();
      set_req(2, 1'b1, 1'b0, 1'b0, 11'h032, '0);
      lk_seq = '{0, 0, 0, 0, 0, 0, 0, 2, 0, 0};
      foreach (lk_seq[k]) begin
         expect_grant("lk_gnt", lk_seq[k], AW'(11'h030 + lk_seq[k]), 1'b1);
         step();
      end
      idle_reqs();
      repeat (3) step();

      // lock with no contention never forces a gap
      do_reset();
      set_req(0, 1'b1, 1'b0, 1'b1, 11'h0A0, '0);
      for (int k = 0; k < 20; k++) begin
         expect_grant("lk_alone", 0, 11'h0A0, 1'b1);
         step();
      end
      @(negedge clock);
      check("lk_alone_state", 300'(bus.lock_state), 300'(1));
      idle_reqs();
      @(negedge clock);
      check("lk_drop_gnt", 300'(bus.grant), 300'(0));
      step();
      @(negedge clock);
      check("lk_drop_state", 300'(bus.lock_state), 300'(0));
      repeat (3) step();

      // write then read of the same address by different requesters
      do_reset();
      set_req(0, 1'b0, 1'b1, 1'b0, 11'h010, aa);
      expect_grant("haz_wr_gnt", 0, 11'h010, 1'b0);
      step();
      idle_reqs();
      set_req(1, 1'b1, 1'b0, 1'b0, 11'h010, '0);
      @(negedge clock);
      check("haz_rd_gnt", 300'(bus.grant), 300'(oh(1)));
      exp_q.push_back({oh(1), aa});
      check("haz_mem_write", 300'(bus.mem_write), 300'(1));
      check("haz_mem_wdata", 300'(bus.mem_writedata), 300'(aa));
      step();
      idle_reqs();
      set_req(2, 1'b1, 1'b1, 1'b0, 11'h040, h55);
      @(negedge clock);
      check("haz_mem_read", 300'(bus.mem_read), 300'(1));
      check("haz_mem_addr", 300'(bus.mem_address), 300'(11'h010));
      check("rw_gnt", 300'(bus.grant), 300'(oh(2)));
      step();
      idle_reqs();
      @(negedge clock);
      check("rw_mem_write", 300'(bus.mem_write), 300'(1));
      check("rw_mem_read", 300'(bus.mem_read), 300'(0));
      repeat (4) step();

      // reset while a read is in flight discards it
      do_reset();
      set_req(1, 1'b1, 1'b0, 1'b0, 11'h050, '0);
      expect_grant("mid_gnt", 1, 11'h050, 1'b0);
      step();
      idle_reqs();
      reset = 1'b1;
      @(negedge clock);
      check("mid_n1_mem_read", 300'(bus.mem_read), 300'(1));
      check("mid_n1_rd_valid", 300'(bus.rd_valid), 300'(0));
      step();
      @(negedge clock);
      check("mid_n2_mem_read", 300'(bus.mem_read), 300'(0));
      check("mid_n2_rd_valid", 300'(bus.rd_valid), 300'(0));
      step();
      reset = 1'b0;
      @(negedge clock);
      check("mid_n3_rd_valid", 300'(bus.rd_valid), 300'(0));
      check("mid_n3_mem_write", 300'(bus.mem_write), 300'(0));
      repeat (3) step();

      check("rd_pending", 300'(exp_q.size()), 300'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
